uart_led_cmd_ctrl: RTL
======================

// Module: uart_led_cmd_ctrl
//
// PURPOSE
// Command sequencer between the UART byte receiver (8N1, one-cycle o_rx_valid strobe) and the LED-array row framebuffer.
// - Parses 5-byte frames: SYNC, CMD, ADDR, DATA, CHK.
// - Validates each frame; on success, drives framebuffer row writes over a valid/ready handshake, or updates brightness.
// - Owns the framebuffer write port and the brightness register; no other block writes either.
//
// PARAMETERS
// CLOCK_RATE_HZ  32'd25_000_000          system clock frequency
// ROWS           8                       framebuffer rows; legal ADDR range is 0..ROWS-1
// ROW_W          8                       row width, 1..8; DATA[ROW_W-1:0] is used
// TIMEOUT_CLKS   CLOCK_RATE_HZ/1000      inter-byte timeout in clocks (1 ms)
// SYNC_BYTE      8'hA5                   frame start marker
//
// PORTS
// i_clk        in   1                clock
// i_rst_n      in   1                synchronous reset, active-low
// i_rx_byte    in   8                received byte; valid only while i_rx_valid=1
// i_rx_valid   in   1                one-cycle strobe per received byte
// o_wr_valid   out  1                framebuffer write request
// i_wr_ready   in   1                framebuffer accepts the write when o_wr_valid & i_wr_ready
// o_wr_addr    out  $clog2(ROWS)     row address
// o_wr_data    out  ROW_W            row pixel data
// o_brightness out  4                global brightness level
// o_busy       out  1                a write or clear sequence is in progress
// o_frame_ok   out  1                one-cycle pulse: frame accepted
// o_frame_err  out  1                one-cycle pulse: frame rejected, timeout or overrun
//
// BEHAVIOUR
// - Reset (i_rst_n=0 at posedge): state=S_SYNC, timeout counter=0.
//   Outputs: o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_brightness=4'hF, o_busy=0, o_frame_ok=0, o_frame_err=0.
//   Reset mid-sequence aborts it; no further writes are issued.
// - States: S_SYNC -> S_CMD -> S_ADDR -> S_DATA -> S_CHK -> {S_WRITE | S_CLEAR | S_SYNC}.
//   Each arrow is taken on i_rx_valid.
//   S_SYNC ignores every byte other than SYNC_BYTE; ignored bytes raise no error.
// - CHK must equal CMD^ADDR^DATA. The check happens on the CHK strobe. Commands:
//   8'h01 WRITE_ROW: ADDR<ROWS required.
//     Next cycle: o_wr_valid=1, o_wr_addr=ADDR, o_wr_data=DATA[ROW_W-1:0], o_busy=1.
//   8'h02 CLEAR: ADDR and DATA are ignored.
//     Enters S_CLEAR, o_busy=1, writes zeros to rows 0..ROWS-1 in ascending order, one row per accepted handshake.
//   8'h03 BRIGHT: o_brightness<=DATA[3:0] on the cycle after CHK; o_frame_ok pulses on that same cycle.
// - Error cases: bad CHK, unknown CMD, or WRITE_ROW with ADDR>=ROWS.
//   o_frame_err pulses on the cycle after CHK; return to S_SYNC; no side effects.
// - Handshake: once o_wr_valid is raised, o_wr_valid, o_wr_addr and o_wr_data hold stable until i_wr_ready=1.
//   o_wr_valid may drop only after the cycle in which the write is accepted.
//   A ready asserted while valid=0 has no effect.
// - WRITE_ROW completion: on acceptance, o_frame_ok pulses on the next cycle, o_busy=0, return to S_SYNC.
//   CLEAR completion: on acceptance of row ROWS-1, same as WRITE_ROW.
//   CLEAR address counter does not wrap.
// - Overrun: an i_rx_valid while o_busy=1 drops the byte and pulses o_frame_err.
//   The sequence in progress continues unaffected.
// - Timeout: in S_CMD..S_CHK the counter increments every cycle and clears on each i_rx_valid.
//   At TIMEOUT_CLKS-1 the frame is abandoned: o_frame_err pulses, state returns to S_SYNC.
//   Counter is held at 0 in S_SYNC, S_WRITE and S_CLEAR.
// - Simultaneous i_rx_valid and timeout expiry: the byte wins and the counter clears.
// - SYNC_BYTE received mid-frame is treated as ordinary CMD/ADDR/DATA/CHK data; there is no resync.
// - o_frame_ok and o_frame_err never assert in the same cycle.
//
// STRUCTURE
// - Shared package uart_led_pkg: state enum (S_SYNC..S_CLEAR), command codes CMD_WRITE/CMD_CLEAR/CMD_BRIGHT,
//   SYNC_BYTE default, brightness reset value.
// - One sub-module: cmd_timeout_timer (counter, clear input, one-cycle expire pulse), parameterised by TIMEOUT_CLKS.
// - The FSM, frame registers and write-port registers stay in this module.
//
// TESTING
// - Send A5 01 03 5A 58 (i_wr_ready=1):
//   expect one write with addr=3, data=8'h5A, then o_frame_ok pulse, then o_busy=0.
// - Send A5 02 00 00 02 with i_wr_ready toggling 1/0:
//   expect 8 writes of 0 to addr 0..7 in order, addr/data stable while ready=0, one o_frame_ok after row 7.
// - Send A5 03 00 07 04: expect o_brightness=7 and o_frame_ok.
//   Then send A5 03 00 07 05 (bad CHK): expect o_frame_err and brightness still 7.
// - Send A5 01 09 FF F7 (ADDR>=ROWS): expect o_frame_err and no o_wr_valid.
//   Then send 33 A5 01 00 01 00: expect the 33 ignored without error, and a write of row 0.
// - Send A5 01, then idle TIMEOUT_CLKS cycles: expect a single o_frame_err.
//   Then a full valid frame is accepted.
// - Start CLEAR with i_wr_ready=0, inject a byte: expect an overrun o_frame_err.
//   Then assert i_rst_n=0 for one cycle: all outputs return to reset values and no write occurs afterwards.

Source files
------------

// File: rtl/uart_led_pkg.sv
// Shared types and constants for the UART LED command sequencer.
package uart_led_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_WRITE,
        S_CLEAR
    } state_t;

    localparam logic [7:0] CMD_WRITE         = 8'h01;
    localparam logic [7:0] CMD_CLEAR         = 8'h02;
    localparam logic [7:0] CMD_BRIGHT        = 8'h03;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [3:0] BRIGHT_RESET      = 4'hF;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout counter: counts while running, clears on i_clr,
// and emits a one-cycle expire pulse when it reaches TIMEOUT_CLKS-1.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CLKS = 25000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] count_q;

    // A byte arriving on the expiry cycle wins over the timeout.
    always_comb begin
        o_expire = i_run && !i_clr && (count_q == LAST);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (!i_run || i_clr || o_expire) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Frame parser and framebuffer/brightness command sequencer fed by a UART
// byte receiver; owns the framebuffer write port and brightness register.
module uart_led_cmd_ctrl
    import uart_led_pkg::*;
#(
    parameter logic [31:0] CLOCK_RATE_HZ = 32'd25_000_000,
    parameter int          ROWS          = 8,
    parameter int          ROW_W         = 8,
    parameter int unsigned TIMEOUT_CLKS  = CLOCK_RATE_HZ / 1000,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_rx_byte,
    input  logic                    i_rx_valid,
    output logic                    o_wr_valid,
    input  logic                    i_wr_ready,
    output logic [$clog2(ROWS)-1:0] o_wr_addr,
    output logic [ROW_W-1:0]        o_wr_data,
    output logic [3:0]              o_brightness,
    output logic                    o_busy,
    output logic                    o_frame_ok,
    output logic                    o_frame_err
);

    localparam int AW = $clog2(ROWS);
    localparam logic [7:0]    ROWS_B   = 8'(ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_t          state, state_nx;
    logic [7:0]      cmd_q, addr_q, data_q;
    logic [AW-1:0]   wr_addr_q;
    logic [ROW_W-1:0] wr_data_q;
    logic [3:0]      bright_q;
    logic            ok_q, err_q;
    logic            ok_nx, err_nx;
    logic            load_write, load_clear, load_bright;
    logic            busy_w, accept, timer_run, expire;

    cmd_timeout_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (timer_run),
        .i_clr   (i_rx_valid),
        .o_expire(expire)
    );

    always_comb begin
        busy_w    = (state == S_WRITE) || (state == S_CLEAR);
        accept    = busy_w && i_wr_ready;
        timer_run = (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CHK);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and frame decision
    always_comb begin
        state_nx    = state;
        ok_nx       = 1'b0;
        err_nx      = 1'b0;
        load_write  = 1'b0;
        load_clear  = 1'b0;
        load_bright = 1'b0;
        case (state)
            S_SYNC: begin
                if (i_rx_valid && (i_rx_byte == SYNC_BYTE)) state_nx = S_CMD;
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (i_rx_valid) begin
                    state_nx = (state == S_CMD)  ? S_ADDR :
                               (state == S_ADDR) ? S_DATA : S_CHK;
                end else if (expire) begin
                    state_nx = S_SYNC;
                    err_nx   = 1'b1;
                end
            end
            S_CHK: begin
                if (i_rx_valid) begin
                    state_nx = S_SYNC;
                    if (i_rx_byte != frame_chk(cmd_q, addr_q, data_q)) begin
                        err_nx = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_WRITE: begin
                                if (addr_q < ROWS_B) begin
                                    state_nx   = S_WRITE;
                                    load_write = 1'b1;
                                end else begin
                                    err_nx = 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                state_nx   = S_CLEAR;
                                load_clear = 1'b1;
                            end
                            CMD_BRIGHT: begin
                                load_bright = 1'b1;
                                ok_nx       = 1'b1;
                            end
                            default: err_nx = 1'b1;
                        endcase
                    end
                end else if (expire) begin
                    state_nx = S_SYNC;
                    err_nx   = 1'b1;
                end
            end
            S_WRITE, S_CLEAR: begin
                if (accept && ((state == S_WRITE) || (wr_addr_q == LAST_ROW))) begin
                    state_nx = S_SYNC;
                    ok_nx    = 1'b1;
                end
                // Overrun coinciding with completion yields to the ok pulse.
                if (i_rx_valid && !ok_nx) err_nx = 1'b1;
            end
            default: state_nx = S_SYNC;
        endcase
    end

    // Frame capture, write-port and brightness registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bright_q  <= BRIGHT_RESET;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ok_q  <= ok_nx;
            err_q <= err_nx;
            if (i_rx_valid) begin
                case (state)
                    S_CMD:   cmd_q  <= i_rx_byte;
                    S_ADDR:  addr_q <= i_rx_byte;
                    S_DATA:  data_q <= i_rx_byte;
                    default: ;
                endcase
            end
            if (load_write) begin
                wr_addr_q <= addr_q[AW-1:0];
                wr_data_q <= data_q[ROW_W-1:0];
            end else if (load_clear) begin
                wr_addr_q <= '0;
                wr_data_q <= '0;
            end else if ((state == S_CLEAR) && accept && (wr_addr_q != LAST_ROW)) begin
                wr_addr_q <= wr_addr_q + AW'(1);
            end
            if (load_bright) bright_q <= data_q[3:0];
        end
    end

    // Outputs
    always_comb begin
        o_busy       = busy_w;
        o_wr_valid   = busy_w;
        o_wr_addr    = wr_addr_q;
        o_wr_data    = wr_data_q;
        o_brightness = bright_q;
        o_frame_ok   = ok_q;
        o_frame_err  = err_q;
    end

endmodule
